// File: rtl/etapa_busqueda.sv
// Instruction-fetch stage: owns the program counter, presents it to the
// external incrementer and instruction memory, and captures the fetched
// instruction into the IF/ID pipeline register. It fetches one instruction
// every two cycles: one cycle presents pc, the next adopts pc+1 from the
// registered incrementer. Stall freezes the stage. A taken branch redirects
// pc and flushes IF/ID, and it takes priority over stall.
module etapa_busqueda #(
    parameter int          PC_W     = 7,
    parameter int          INSTR_W  = 32,
    parameter int unsigned RESET_PC = 0,
    parameter int          CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PC_W-1:0]    pc_inc,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc,
    output logic               if_id_valid,
    output logic [CNT_W-1:0]   fetch_count
);

    // FETCH: pc is stable and the incrementer samples it on this edge.
    // WAIT_INC: the incrementer output now holds pc+1 and can be adopted.
    typedef enum logic {
        FETCH    = 1'b0,
        WAIT_INC = 1'b1
    } state_t;

    localparam logic [PC_W-1:0]  RESET_PC_V = PC_W'(RESET_PC);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    state_t             state_reg,   state_next;
    logic [PC_W-1:0]    pc_reg,      pc_next;
    logic [INSTR_W-1:0] instr_reg,   instr_next;
    logic [PC_W-1:0]    id_pc_reg,   id_pc_next;
    logic               valid_reg,   valid_next;
    logic [CNT_W-1:0]   cnt_reg,     cnt_next;

    // Register all stage state. Reset is asynchronous, so the outputs return
    // to their reset values right away and do not wait for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= FETCH;
            pc_reg    <= RESET_PC_V;
            instr_reg <= '0;
            id_pc_reg <= '0;
            valid_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            id_pc_reg <= id_pc_next;
            valid_reg <= valid_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Compute the next state and the next register values. Each register
    // holds by default, so a stall needs no explicit branch of its own.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        instr_next = instr_reg;
        id_pc_next = id_pc_reg;
        valid_next = valid_reg;
        cnt_next   = cnt_reg;

        if (branch_taken) begin
            // Redirect and discard the instruction in flight. The stale
            // incrementer value is never used, because FETCH ignores pc_inc.
            pc_next    = branch_target;
            valid_next = 1'b0;
            state_next = FETCH;
        end else if (!stall) begin
            case (state_reg)
                FETCH: begin
                    instr_next = instr_in;
                    id_pc_next = pc_reg;
                    valid_next = 1'b1;
                    cnt_next   = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
                    state_next = WAIT_INC;
                end
                WAIT_INC: begin
                    // pc_inc wraps naturally at the top of the address space.
                    pc_next    = pc_inc;
                    valid_next = 1'b0;
                    state_next = FETCH;
                end
                default: begin
                    state_next = FETCH;
                end
            endcase
        end
    end

    assign pc          = pc_reg;
    assign if_id_instr = instr_reg;
    assign if_id_pc    = id_pc_reg;
    assign if_id_valid = valid_reg;
    assign fetch_count = cnt_reg;

endmodule

// File: tb/tb_etapa_busqueda.sv
// Bench for etapa_busqueda. It supplies a registered incrementer and a
// combinational instruction memory. A behavioural model describes what the
// stage should do each cycle, and every check compares the DUT with that model
// or with a constant from the test plan.
module tb_etapa_busqueda;

    localparam int PC_W    = 7;
    localparam int INSTR_W = 32;
    localparam int CNT_W   = 8;
    localparam int PC_MOD  = 1 << PC_W;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [PC_W-1:0]    pc_inc;
    logic [PC_W-1:0]    inc_reg = '0;
    logic [INSTR_W-1:0] instr_in;
    logic               stall = 1'b0;
    logic               branch_taken = 1'b0;
    logic [PC_W-1:0]    branch_target = '0;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] if_id_instr;
    logic [PC_W-1:0]    if_id_pc;
    logic               if_id_valid;
    logic [CNT_W-1:0]   fetch_count;

    logic [INSTR_W-1:0] mem [PC_MOD];

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int m_pc, m_idpc, m_cnt;
    logic [INSTR_W-1:0] m_instr;
    bit m_valid, m_waiting;

    etapa_busqueda #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(0), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .pc_inc(pc_inc), .instr_in(instr_in),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .pc(pc), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
        .if_id_valid(if_id_valid), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // External incrementer: registers pc+1, so its output lags pc by one cycle.
    always @(posedge clk) inc_reg <= pc + 7'd1;
    assign pc_inc   = inc_reg;
    assign instr_in = mem[pc];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".pc"},    32'(pc),          32'(m_pc));
        check({tag, ".instr"}, 32'(if_id_instr), m_instr);
        check({tag, ".idpc"},  32'(if_id_pc),    32'(m_idpc));
        check({tag, ".valid"}, 32'(if_id_valid), 32'(m_valid));
        check({tag, ".cnt"},   32'(fetch_count), 32'(m_cnt));
    endtask

    task automatic model_reset();
        m_pc = 0; m_idpc = 0; m_cnt = 0; m_instr = '0;
        m_valid = 1'b0; m_waiting = 1'b0;
    endtask

    // One clock cycle of intended behaviour, written from the stage's rules.
    task automatic model_cycle(input bit s, input bit b, input int t);
        if (b) begin
            m_pc = t; m_valid = 1'b0; m_waiting = 1'b0;
        end else if (!s) begin
            if (!m_waiting) begin
                m_instr = mem[m_pc];
                m_idpc  = m_pc;
                m_valid = 1'b1;
                if (m_cnt < CNT_SAT) m_cnt = m_cnt + 1;
                m_waiting = 1'b1;
            end else begin
                m_pc = (m_pc + 1) % PC_MOD;
                m_valid = 1'b0;
                m_waiting = 1'b0;
            end
        end
    endtask

    // Drive inputs at the falling edge, clock once, then compare at the next falling edge.
    task automatic step(input string tag, input bit s, input bit b, input int t);
        stall = s; branch_taken = b; branch_target = PC_W'(t);
        @(posedge clk);
        model_cycle(s, b, t);
        @(negedge clk);
        check_model(tag);
        $display("step %-8s stall=%0b br=%0b tgt=%02h | pc=%02h idpc=%02h instr=%08h v=%0b cnt=%0d",
                 tag, s, b, t, pc, if_id_pc, if_id_instr, if_id_valid, fetch_count);
    endtask

    // Assert reset in the middle of a low clock phase and check that the outputs clear before any edge.
    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_model(tag);
        $display("async reset %s at %0t: pc=%02h v=%0b cnt=%0d", tag, $time, pc, if_id_valid, fetch_count);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < PC_MOD; i++) mem[i] = INSTR_W'(i * 16);
        model_reset();

        // Reset state
        @(negedge clk); @(negedge clk);
        check_model("reset");
        rst_n = 1'b1;

        // Start-up sequence: capture pulses on cycles 1, 3 and 5 for pc 0, 1 and 2
        for (int k = 1; k <= 5; k++) begin
            step("start", 0, 0, 0);
            if (k % 2 == 1) begin
                check("start.valid", 32'(if_id_valid), 32'd1);
                check("start.idpc",  32'(if_id_pc),    32'((k - 1) / 2));
                check("start.instr", if_id_instr,      32'(((k - 1) / 2) * 16));
            end
        end
        check("start.cnt3", 32'(fetch_count), 32'd3);

        // Advance to the capture of pc=4, then stall for three cycles
        for (int k = 0; k < 4; k++) step("adv", 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step("stall", 1, 0, 0);
            check("stall.pc",    32'(pc),          32'd4);
            check("stall.idpc",  32'(if_id_pc),    32'd4);
            check("stall.valid", 32'(if_id_valid), 32'd1);
            check("stall.cnt",   32'(fetch_count), 32'd5);
        end
        step("resume", 0, 0, 0);
        check("resume.pc", 32'(pc), 32'd5);

        // Branch taken during WAIT_INC
        step("fetch5", 0, 0, 0);
        step("brwait", 0, 1, 'h40);
        check("brwait.pc",    32'(pc),          32'h40);
        check("brwait.valid", 32'(if_id_valid), 32'd0);
        step("brtgt", 0, 0, 0);
        check("brtgt.idpc", 32'(if_id_pc), 32'h40);
        step("brnext", 0, 0, 0);
        check("brnext.pc", 32'(pc), 32'h41);

        // Branch and stall together in FETCH: the branch wins
        step("brstall", 1, 1, 'h10);
        check("brstall.pc",    32'(pc),          32'h10);
        check("brstall.valid", 32'(if_id_valid), 32'd0);
        step("brst2", 0, 0, 0);
        check("brst2.idpc",  32'(if_id_pc),    32'h10);
        check("brst2.valid", 32'(if_id_valid), 32'd1);

        // pc wrap-around from 126
        step("towrap", 0, 1, 126);
        for (int k = 0; k < 7; k++) begin
            step("wrap", 0, 0, 0);
            if (k % 2 == 0)
                check("wrap.idpc", 32'(if_id_pc), 32'((126 + k / 2) % PC_MOD));
        end

        // Random program contents and random stall/branch traffic
        for (int i = 0; i < PC_MOD; i++) mem[i] = $urandom;
        for (int i = 0; i < 400; i++) begin
            bit s, b;
            int t;
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 7) == 0);
            t = ($urandom_range(0, 3) == 0) ? $urandom_range(124, 127) : $urandom_range(0, 127);
            step("rand", s, b, t);
        end

        // Run freely until the fetch counter saturates
        for (int i = 0; i < 520; i++) step("sat", 0, 0, 0);
        check("sat.cnt", 32'(fetch_count), 32'(CNT_SAT));

        // Asynchronous reset while the stage sits in WAIT_INC with fetch_count=9
        async_reset("rst1");
        for (int k = 0; k < 17; k++) step("cnt9", 0, 0, 0);
        check("cnt9.cnt",   32'(fetch_count), 32'd9);
        check("cnt9.valid", 32'(if_id_valid), 32'd1);
        async_reset("rst2");
        check("rst2.pc",  32'(pc),          32'd0);
        check("rst2.cnt", 32'(fetch_count), 32'd0);
        step("restart", 0, 0, 0);
        check("restart.idpc",  32'(if_id_pc),    32'd0);
        check("restart.valid", 32'(if_id_valid), 32'd1);
        check("restart.cnt",   32'(fetch_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/etapa_busqueda.md
Name: etapa_busqueda

Overview:
- Instruction-fetch (IF) stage that owns the program counter.
- Drives `pc` to the PC incrementer and to instruction memory.
- Consumes the incrementer's registered `pc_inc` one cycle later.
- Captures instruction and PC into the IF/ID pipeline register for the decode stage.
- Handles stall and taken-branch redirect/flush from later stages.

Parameters:
- PC_W, 7, program counter width; must match the incrementer.
- INSTR_W, 32, instruction word width.
- RESET_PC, 0, PC value loaded on reset.
- CNT_W, 8, width of the fetched-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc_inc  in  PC_W  pc+1 from the incrementer; registered there, so valid one cycle after `pc` is presented.
- instr_in  in  INSTR_W  instruction memory read data for current `pc` (combinational memory).
- stall  in  1  downstream hazard; freeze this stage.
- branch_taken  in  1  single-cycle redirect request from a later stage.
- branch_target  in  PC_W  redirect address, valid with branch_taken.
- pc  out  PC_W  current program counter.
- if_id_instr  out  INSTR_W  captured instruction.
- if_id_pc  out  PC_W  PC of the captured instruction.
- if_id_valid  out  1  IF/ID register holds a valid instruction.
- fetch_count  out  CNT_W  number of instructions issued to IF/ID; saturating.

Behaviour:
- Reset (async, rst_n=0), all outputs and state registered:
  - state=FETCH, pc=RESET_PC.
  - if_id_instr=0, if_id_pc=0, if_id_valid=0, fetch_count=0.
- FSM states, 2-state:
  - FETCH: `pc` stable; incrementer samples it this edge.
  - WAIT_INC: `pc_inc` now equals pc+1.
- FETCH, no stall, no branch:
  - if_id_instr<=instr_in, if_id_pc<=pc, if_id_valid<=1.
  - fetch_count<=fetch_count+1, saturating at 2^CNT_W-1.
  - state<=WAIT_INC; pc unchanged.
- WAIT_INC, no stall, no branch:
  - pc<=pc_inc, if_id_valid<=0 (bubble), state<=FETCH.
  - IF/ID data registers hold their values.
- Throughput: one instruction per 2 cycles. if_id_valid is a 1-cycle pulse when unstalled.
- stall=1 (no branch): pc, state, all if_id_* and fetch_count hold.
  - Decode accepts an instruction only when if_id_valid=1 and stall=0.
- branch_taken=1, any state, overrides stall:
  - pc<=branch_target, if_id_valid<=0 (flush), state<=FETCH.
  - fetch_count unchanged; instruction in flight is discarded.
  - Target fetched 1 cycle later; target+1 follows 2 cycles after that.
- Wrap-around: pc=2^PC_W-1 → pc_inc=0 → pc becomes 0. No error flag.
- pc_inc is never used in FETCH, so a stale incrementer value after reset or branch has no effect.
- Reset asserted mid-operation: immediate return to reset values regardless of clock.

Test Plan:
- Reset release, RESET_PC=0, instr_in=pc*16, no stall:
  - if_id_valid pulses on cycles 1,3,5 with if_id_pc=0,1,2 and if_id_instr=0x00,0x10,0x20.
  - fetch_count=3.
- stall=1 for 3 cycles while if_id_valid=1 with if_id_pc=4:
  - pc, if_id_pc=4, if_id_valid=1 and fetch_count hold for all 3 cycles.
  - Sequence resumes at pc=5 after release.
- branch_taken with branch_target=0x40 during WAIT_INC:
  - next cycle pc=0x40, if_id_valid=0.
  - following edge if_id_pc=0x40; then pc=0x41.
- branch_taken and stall both 1 in FETCH:
  - branch wins: pc=target, if_id_valid=0, state=FETCH.
- Start at pc=126:
  - if_id_pc sequence is 126, 127, 0, 1; no stall of the sequence at wrap.
- Assert rst_n low asynchronously mid-WAIT_INC with fetch_count=9:
  - outputs go to reset values before the next clock edge.
  - fetch sequence restarts at RESET_PC.
